jt49_mave_mc: RTL and testbench
===============================

// Module: jt49_mave_mc
// PURPOSE
//  Multi-channel moving-average filter for time-multiplexed PSG channel audio.
//  Each of CH channels keeps its own history and running sum. The window is 2^win
//  samples and win is selectable at run time. One shared delay RAM holds the
//  history. Placed after the channel mixer and before the DAC interpolator.
// PARAMETERS
//  DW     8  sample width, signed two's complement
//  DEPTH  5  log2 of max window; history RAM = CH*2^DEPTH words of DW bits
//  CH     2  channel count (>=1); CW=max(1,$clog2(CH))
// PORTS
//  clk        in   1      clock
//  rst        in   1      reset, synchronous, active-high
//  cen        in   1      clock enable; no state changes when low
//  win        in   3      log2 window, clamped to DEPTH; change triggers flush
//  din_valid  in   1      sample present on din/din_ch
//  din_ready  out  1      high only in RUN; accept = cen&din_valid&din_ready
//  din        in   DW     signed input sample
//  din_ch     in   CW     channel index of din; values >=CH ignored (no accept)
//  dout_valid out  1      one-cen-cycle pulse, filtered sample ready
//  dout       out  DW     signed average for dout_ch
//  dout_ch    out  CW     channel of dout
// BEHAVIOUR
//  Reset: dout=0, dout_ch=0, dout_valid=0, din_ready=0, ptrs/accs=0; FSM->CLEAR.
//  FSM (advances on cen only):
//   CLEAR: clr_cnt 0..CH*2^DEPTH-1 writes 0 to RAM, one word per cen; ready=0.
//          Last word -> RUN, win_q<=clamp(win). rst in CLEAR restarts at 0.
//   RUN: ready=1. If clamp(win)!=win_q -> CLEAR. The in-flight sample is dropped
//        and its dout_valid suppressed.
//  Stage 1 (accept cycle):
//   - old = RAM[ch][(ptr[ch]-2^win_q) mod 2^DEPTH], read-first.
//     When win_q=DEPTH the address equals ptr and the pre-write value is read.
//   - RAM[ch][ptr[ch]] <= din; ptr[ch]++ wraps mod 2^DEPTH.
//   - diff = sext(din) - sext(old), DW+1 bits signed.
//  Stage 2: acc[ch] <= acc[ch] + sext(diff), acc DW+DEPTH bits signed, no overflow.
//   dout <= (acc_new >>> win_q)[DW-1:0] (arith shift); dout_valid=1; dout_ch=ch.
//  Latency: 2 cen-qualified cycles from accept to dout_valid.
//  Full throughput: one sample per cen on any channel order.
//  Back-to-back same channel: acc read-modify-write happens in one stage, so no
//  hazard. ptr is updated in stage 1, so the next read sees the new ptr.
//  win=0: dout equals the current sample (old=din just written one slot back).
//  Startup: zeros fill the window, so dout ramps from 0.
//  acc never overflows: |acc| <= 2^DEPTH * 2^(DW-1).
//  cen low: pipeline holds; dout_valid stays high until the next cen cycle.
// CONFIGURATION
//  JT49_MAVE_ROUND_EN defined:
//   - round half up: dout = ((acc_new + 2^(win_q-1)) >>> win_q);
//   - bias added only when win_q>0; the adder is DW+DEPTH+1 wide, then truncated.
//  JT49_MAVE_ROUND_EN undefined: plain arithmetic shift (floor).
//  Bit-exact with earlier filters.
// TESTING
//  1 rst 1 cycle, cen=1 -> din_ready=0 for exactly 64 cycles (CH=2,DEPTH=5),
//    then 1; dout=0.
//  2 win=2, ch0 din=+8 x4, ch1 din=-8 x4 interleaved -> ch0 dout 2,4,6,8;
//    ch1 dout -2,-4,-6,-8; each 2 cycles after accept.
//  3 win=5, ch0 constant 100 for 40 samples -> dout reaches 100 at sample 32
//    and holds (ptr wrap, read-first).
//  4 win 2->3 mid-stream -> din_ready low 64 cycles; in-flight dout_valid
//    suppressed; next dout = din/8.
//  5 cen toggled 1/0, din_ch=3 (>=CH) with valid -> not accepted, no dout_valid;
//    state frozen while cen=0.
//  6 ROUND_EN, win=1, samples 0 then 1 -> dout 1 (floor build: 0);
//    samples -1,0 -> 0 (floor build: -1).

Source files
------------

// File: rtl/jt49_mave_mc_if.sv
// Sample stream bus for jt49_mave_mc: input handshake and filtered-output strobe.
// The master drives samples in; the slave (the filter) answers with averages.
interface jt49_mave_mc_if #(
  parameter int DW = 8,
  parameter int CH = 2,
  parameter int CW = (CH > 1) ? $clog2(CH) : 1
);
  logic          din_valid;
  logic          din_ready;
  logic [DW-1:0] din;
  logic [CW-1:0] din_ch;
  logic          dout_valid;
  logic [DW-1:0] dout;
  logic [CW-1:0] dout_ch;

  modport master (output din_valid, din, din_ch,
                  input  din_ready, dout_valid, dout, dout_ch);
  modport slave  (input  din_valid, din, din_ch,
                  output din_ready, dout_valid, dout, dout_ch);
endinterface

// File: rtl/jt49_mave_mc.sv
// Multi-channel moving-average filter over a shared history RAM, window 2^win.
// Optional build macro JT49_MAVE_ROUND_EN selects round-half-up instead of floor.
module jt49_mave_mc #(
  parameter int DW    = 8,
  parameter int DEPTH = 5,
  parameter int CH    = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_cen,
  input  logic [2:0]       i_win,
  jt49_mave_mc_if.slave    bus
);
  localparam int CW   = (CH > 1) ? $clog2(CH) : 1;
  localparam int AW   = CW + DEPTH;
  localparam int NW   = CH * (2 ** DEPTH);
  localparam int QW   = $clog2(DEPTH + 1);
  localparam int ACCW = DW + DEPTH;

  typedef enum logic {S_CLEAR, S_RUN} state_t;

  state_t                   r_state;
  logic [AW-1:0]            r_clr_cnt;
  logic [QW-1:0]            r_win_q;
  logic                     r_ready;
  logic [DEPTH-1:0]         r_ptr [CH];
  logic signed [ACCW-1:0]   r_acc [CH];
  logic [DW-1:0]            r_ram [2**AW];

  logic                     r_s1_valid;
  logic [CW-1:0]            r_s1_ch;
  logic signed [DW-1:0]     r_s1_din;
  logic signed [DW-1:0]     r_s1_old;

  logic                     r_dout_valid;
  logic [DW-1:0]            r_dout;
  logic [CW-1:0]            r_dout_ch;

  logic [QW-1:0]            w_win_clamp;
  logic                     w_ch_ok;
  logic                     w_flush;
  logic                     w_accept;
  logic                     w_clr_last;
  logic [DEPTH-1:0]         w_cur_ptr;
  logic [DEPTH-1:0]         w_step;
  logic [AW-1:0]            w_wr_addr;
  logic [AW-1:0]            w_rd_addr;
  logic signed [DW:0]       w_diff;
  logic signed [ACCW-1:0]   w_acc_new;
  logic [DW-1:0]            w_avg;
`ifdef JT49_MAVE_ROUND_EN
  logic signed [ACCW:0]     w_rnd;
`endif

  always_comb begin
    // NOTE: every signal here is assigned on every pass, so no latch can be inferred.
    w_win_clamp = (32'(i_win) > DEPTH) ? QW'(DEPTH) : QW'(i_win);
    w_ch_ok     = 32'(bus.din_ch) < CH;
    w_flush     = (r_state == S_RUN) && (w_win_clamp != r_win_q);
    w_accept    = i_cen && bus.din_valid && r_ready && w_ch_ok && !w_flush;
    w_clr_last  = r_clr_cnt == AW'(NW - 1);
    w_cur_ptr   = r_ptr[bus.din_ch];
    // Step of 2^DEPTH wraps to zero: the oldest slot is the one about to be overwritten.
    w_step      = DEPTH'(1) << r_win_q;
    w_wr_addr   = {bus.din_ch, w_cur_ptr};
    w_rd_addr   = {bus.din_ch, DEPTH'(w_cur_ptr - w_step)};
    w_diff      = {r_s1_din[DW-1], r_s1_din} - {r_s1_old[DW-1], r_s1_old};
    w_acc_new   = r_acc[r_s1_ch] + ACCW'(w_diff);
`ifdef JT49_MAVE_ROUND_EN
    w_rnd       = (ACCW+1)'(w_acc_new)
                + ((r_win_q != '0) ? ((ACCW+1)'(1) << (r_win_q - QW'(1))) : '0);
    w_avg       = DW'(w_rnd >>> r_win_q);
`else
    w_avg       = DW'(w_acc_new >>> r_win_q);
`endif
  end

  // NOTE: the history RAM has no reset; the CLEAR sweep zeroes it, keeping it block-RAM friendly.
  always_ff @(posedge clk) begin
    if (i_cen && !rst) begin
      if (r_state == S_CLEAR) r_ram[r_clr_cnt] <= '0;
      else if (w_accept)      r_ram[w_wr_addr] <= bus.din;
      if (w_accept)           r_s1_old <= r_ram[w_rd_addr];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_CLEAR;
      r_clr_cnt    <= '0;
      r_win_q      <= '0;
      r_ready      <= 1'b0;
      r_s1_valid   <= 1'b0;
      r_s1_ch      <= '0;
      r_s1_din     <= '0;
      r_dout_valid <= 1'b0;
      r_dout       <= '0;
      r_dout_ch    <= '0;
      for (int i = 0; i < CH; i++) begin
        r_ptr[i] <= '0;
        r_acc[i] <= '0;
      end
    end else if (i_cen) begin
      // NOTE: state registers use <= so every update sees pre-edge values; this also makes the RAM read-first.
      r_dout_valid <= 1'b0;
      r_s1_valid   <= w_accept;
      if (w_accept) begin
        r_s1_ch               <= bus.din_ch;
        r_s1_din              <= bus.din;
        r_ptr[bus.din_ch]     <= w_cur_ptr + DEPTH'(1);
      end
      if (r_s1_valid && !w_flush) begin
        r_acc[r_s1_ch] <= w_acc_new;
        r_dout         <= w_avg;
        r_dout_ch      <= r_s1_ch;
        r_dout_valid   <= 1'b1;
      end
      case (r_state)
        S_CLEAR: begin
          r_clr_cnt <= r_clr_cnt + AW'(1);
          if (w_clr_last) begin
            r_state   <= S_RUN;
            r_ready   <= 1'b1;
            r_win_q   <= w_win_clamp;
            r_clr_cnt <= '0;
          end
        end
        S_RUN: begin
          // A window change restarts from an all-zero history, so sums must restart too.
          if (w_flush) begin
            r_state   <= S_CLEAR;
            r_ready   <= 1'b0;
            r_clr_cnt <= '0;
            for (int i = 0; i < CH; i++) begin
              r_ptr[i] <= '0;
              r_acc[i] <= '0;
            end
          end
        end
      endcase
    end
  end

  assign bus.din_ready  = r_ready;
  assign bus.dout_valid = r_dout_valid;
  assign bus.dout       = r_dout;
  assign bus.dout_ch    = r_dout_ch;
endmodule

// File: tb/tb_jt49_mave_mc.sv
// Scoreboard bench for jt49_mave_mc: a sliding-window model predicts each average,
// a monitor compares outputs, and a small three-channel instance covers bad channel indices.
module tb_jt49_mave_mc;
  localparam int DW    = 8;
  localparam int DEPTH = 5;
  localparam int CH    = 2;
  localparam int CW    = 1;
  localparam int NW    = CH * (1 << DEPTH);

  typedef struct {
    int ch;
    int val;
    int at;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       cen;
  logic [2:0] win;
  logic [2:0] win3;

  jt49_mave_mc_if #(.DW(DW), .CH(CH)) bus ();
  jt49_mave_mc_if #(.DW(DW), .CH(3))  bus3 ();

  jt49_mave_mc #(.DW(DW), .DEPTH(DEPTH), .CH(CH)) dut (
    .clk   (clk),
    .rst   (rst),
    .i_cen (cen),
    .i_win (win),
    .bus   (bus)
  );

  jt49_mave_mc #(.DW(DW), .DEPTH(2), .CH(3)) dut3 (
    .clk   (clk),
    .rst   (rst),
    .i_cen (cen),
    .i_win (win3),
    .bus   (bus3)
  );

  always #5 clk = ~clk;

  int   total = 0;
  int   bad = 0;
  int   cen_edges = 0;
  int   cur_w;
  exp_t exp_q[$];
  int   hist[CH][$];

  task automatic check(input string name, input int act, input int expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  function automatic int clampw(input int w);
    return (w > DEPTH) ? DEPTH : w;
  endfunction

  // Average of the last 2^cur_w samples of a channel; missing history counts as zero.
  function automatic int model_push(input int ch, input int s);
    int sum = 0;
    int n = 1 << cur_w;
    hist[ch].push_back(s);
    if (hist[ch].size() > (1 << DEPTH)) void'(hist[ch].pop_front());
    for (int i = 0; i < n; i++)
      if (i < hist[ch].size()) sum += hist[ch][hist[ch].size() - 1 - i];
`ifdef JT49_MAVE_ROUND_EN
    if (cur_w > 0) sum += 1 << (cur_w - 1);
`endif
    return sum >>> cur_w;
  endfunction

  task automatic clear_model();
    for (int c = 0; c < CH; c++) hist[c].delete();
  endtask

  task automatic send(input bit v, input int ch, input int s, input bit c);
    @(negedge clk);
    cen           = c;
    bus.din_valid = v;
    bus.din_ch    = CW'(ch);
    bus.din       = DW'(s);
    if (v) check("din_ready", int'(bus.din_ready), 1);
    if (v && c) begin
      exp_t e;
      e.ch  = ch;
      e.val = model_push(ch, s);
      e.at  = cen_edges + 2;
      exp_q.push_back(e);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) send(1'b0, 0, 0, 1'b1);
  endtask

  task automatic wait_clear(input string nm, input bit is_rst);
    int n = 0;
    forever begin
      @(negedge clk);
      if (is_rst && n == 0) begin
        check("reset dout", int'(bus.dout), 0);
        check("reset dout_ch", int'(bus.dout_ch), 0);
        check("reset dout_valid", int'(bus.dout_valid), 0);
      end
      rst = 1'b0;
      if (bus.din_ready) break;
      n++;
      if (n > 4 * NW) break;
    end
    check(nm, n, NW);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    cen = 1'b1;
    bus.din_valid = 1'b0;
    exp_q.delete();
    clear_model();
    cur_w = clampw(int'(win));
    wait_clear("reset ready-low cycles", 1'b1);
  endtask

  task automatic set_win(input int w);
    int cw = clampw(w);
    @(negedge clk);
    cen = 1'b1;
    bus.din_valid = 1'b0;
    win = 3'(w);
    if (cw != cur_w) begin
      // Anything that would emerge on or after the flush edge is lost.
      while (exp_q.size() > 0 && exp_q[$].at > cen_edges) void'(exp_q.pop_back());
      clear_model();
      cur_w = cw;
      wait_clear("flush ready-low cycles", 1'b0);
    end
  endtask

  initial begin : monitor
    exp_t e;
    bit ce;
    logic [DW:0] prev = '0;
    forever begin
      @(posedge clk);
      ce = cen;
      if (ce) cen_edges++;
      #1;
      if (!ce && !rst)
        check("hold while cen low", int'({bus.dout_valid, bus.dout}), int'(prev));
      else if (ce && bus.dout_valid) begin
        if (exp_q.size() == 0) check("unexpected dout_valid", 1, 0);
        else begin
          e = exp_q.pop_front();
          check("dout_ch", int'(bus.dout_ch), e.ch);
          check("dout", int'($signed(bus.dout)), e.val);
          check("latency", cen_edges, e.at);
        end
      end
      prev = {bus.dout_valid, bus.dout};
    end
  end

  initial begin : watchdog
    #400000;
    bad++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin : stimulus
    int n;
    cen = 1'b1;
    rst = 1'b1;
    win = 3'd2;
    win3 = 3'd0;
    bus.din_valid = 1'b0;
    bus.din = '0;
    bus.din_ch = '0;
    bus3.din_valid = 1'b0;
    bus3.din = '0;
    bus3.din_ch = '0;

    do_reset();

    for (int i = 0; i < 4; i++) begin
      send(1'b1, 0, 8, 1'b1);
      send(1'b1, 1, -8, 1'b1);
    end
    idle(4);

    set_win(5);
    repeat (40) send(1'b1, 0, 100, 1'b1);
    idle(4);

    send(1'b1, 1, 50, 1'b1);
    send(1'b1, 1, -30, 1'b1);
    set_win(3);
    send(1'b1, 0, 16, 1'b1);
    send(1'b1, 0, 16, 1'b1);
    idle(4);

    for (int i = 0; i < 24; i++)
      send(1'b1, i % 2, int'($urandom_range(0, 255)) - 128, (i % 2 == 0) || (i % 3 == 0));
    idle(4);

    @(negedge clk);
    cen = 1'b1;
    bus.din_valid = 1'b0;
    bus3.din_valid = 1'b1;
    bus3.din_ch = 2'd3;
    bus3.din = 8'd5;
    n = 0;
    repeat (4) begin
      @(negedge clk);
      bus3.din_valid = 1'b0;
      if (bus3.dout_valid) n++;
    end
    check("channel >= CH ignored", n, 0);
    @(negedge clk);
    bus3.din_valid = 1'b1;
    bus3.din_ch = 2'd2;
    bus3.din = 8'd40;
    @(negedge clk);
    bus3.din_valid = 1'b0;
    @(negedge clk);
    check("ch2 dout_valid", int'(bus3.dout_valid), 1);
    check("ch2 dout", int'($signed(bus3.dout)), 40);
    check("ch2 dout_ch", int'(bus3.dout_ch), 2);

    set_win(1);
    send(1'b1, 0, 0, 1'b1);
    send(1'b1, 0, 1, 1'b1);
    send(1'b1, 0, -1, 1'b1);
    send(1'b1, 0, 0, 1'b1);
    idle(4);

    set_win(0);
    for (int i = 0; i < 6; i++) send(1'b1, i % 2, int'($urandom_range(0, 255)) - 128, 1'b1);
    idle(3);

    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 99) < 3) set_win(int'($urandom_range(0, 7)));
      else send($urandom_range(0, 3) != 0, int'($urandom_range(0, CH - 1)),
                int'($urandom_range(0, 255)) - 128, $urandom_range(0, 9) != 0);
    end
    idle(6);

    check("scoreboard drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
